// File: rtl/pam4_tx_channel_if.sv
// Bus bundle for the PAM4 transmit channel model: tap loading, symbol input
// and ISI sample output. The master side is the stimulus/host.
interface pam4_tx_channel_if #(
    parameter int R = 8
);
    logic                 load_mem;
    logic [7:0]           location;
    logic [4*R-1:0]       mem_data;
    logic                 done_load;
    logic [1:0]           symbol_in;
    logic                 symbol_in_valid;
    logic                 symbol_in_ready;
    logic signed [R-1:0]  signal_out;
    logic                 signal_out_valid;

    modport master (
        output load_mem, location, mem_data, symbol_in, symbol_in_valid,
        input  done_load, symbol_in_ready, signal_out, signal_out_valid
    );

    modport slave (
        input  load_mem, location, mem_data, symbol_in, symbol_in_valid,
        output done_load, symbol_in_ready, signal_out, signal_out_valid
    );
endinterface

// File: rtl/pam4_tx_channel.sv
// PAM4 transmit channel: Gray-coded symbols are mapped to levels, run through
// an L-tap FIR (taps m*2^-y) in a two-stage pipeline and saturated to R bits.
module pam4_tx_channel #(
    parameter int PULSE_RESPONSE_LENGTH = 5,
    parameter int SIGNAL_RESOLUTION     = 8,
    parameter int SYMBOL_SEPERATION     = 56
) (
    input  logic               clk,
    input  logic               rstn,
    pam4_tx_channel_if.slave   bus
);
    localparam int L  = PULSE_RESPONSE_LENGTH;
    localparam int R  = SIGNAL_RESOLUTION;
    localparam int S  = SYMBOL_SEPERATION;
    localparam int HW = $clog2(3 * S / 2 + 1) + 1;
    localparam int TW = HW + 2 * R;
    localparam int SW = TW + $clog2(L) + 1;

    localparam logic signed [HW-1:0] LVL_HI  = HW'(3 * S / 2);
    localparam logic signed [HW-1:0] LVL_LO  = HW'(S / 2);
    localparam logic signed [SW-1:0] SAT_MAX = (SW'(1) <<< (R - 1)) - SW'(1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic logic signed [HW-1:0] level_of(input logic [1:0] sym);
        case (sym)
            2'b00:   level_of = -LVL_HI;
            2'b01:   level_of = -LVL_LO;
            2'b11:   level_of = LVL_LO;
            2'b10:   level_of = LVL_HI;
            default: level_of = '0;
        endcase
    endfunction

    // Floor-rounded scaling falls out of the arithmetic right shift.
    function automatic logic signed [TW-1:0] tap_term(input logic signed [HW-1:0] h,
                                                      input logic [4*R-1:0]       c);
        logic signed [2*R-1:0] m;
        logic signed [TW-1:0]  p;
        m = c[4*R-1:2*R];
        p = TW'(h) * TW'(m);
        return p >>> c[2*R-1:0];
    endfunction

    logic [4*R-1:0]        coef_q    [L];
    logic [4*R-1:0]        coef_d    [L];
    logic [L-1:0]          written_q, written_d;
    logic                  done_q, done_d;
    state_t                state_q, state_d;
    logic                  ready_q, ready_d;
    logic signed [HW-1:0]  hist_q    [L];
    logic signed [HW-1:0]  hist_d    [L];
    logic signed [TW-1:0]  term_q    [L];
    logic signed [TW-1:0]  term_d    [L];
    logic                  v1_q, v1_d;
    logic signed [R-1:0]   out_q, out_d;
    logic                  vout_q, vout_d;
    logic                  accept_s;
    logic signed [SW-1:0]  sum_s;

    // Tap writes: in-range locations update the tap and its written bit.
    always_comb begin
        coef_d    = coef_q;
        written_d = written_q;
        for (int k = 0; k < L; k++) begin
            if (bus.load_mem && (bus.location == 8'(k))) begin
                coef_d[k]    = bus.mem_data;
                written_d[k] = 1'b1;
            end else begin
                coef_d[k]    = coef_q[k];
                written_d[k] = written_q[k];
            end
        end
    end

    // Mode control; ready is precomputed from the next state so it stays a flop.
    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        case (state_q)
            ST_LOAD: begin
                if (&written_q) begin
                    state_d = bus.load_mem ? ST_HOLD : ST_RUN;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_LOAD;
                    done_d  = 1'b0;
                end
            end
            ST_RUN:  state_d = bus.load_mem ? ST_HOLD : ST_RUN;
            ST_HOLD: state_d = bus.load_mem ? ST_HOLD : ST_RUN;
            default: begin
                state_d = ST_LOAD;
                done_d  = 1'b0;
            end
        endcase
        ready_d = (state_d == ST_RUN);
    end

    // History shift and stage-1 products use the post-shift history.
    always_comb begin
        accept_s = bus.symbol_in_valid & ready_q;
        hist_d   = hist_q;
        term_d   = term_q;
        if (accept_s) begin
            hist_d[0] = level_of(bus.symbol_in);
            for (int k = 1; k < L; k++) begin
                hist_d[k] = hist_q[k-1];
            end
            for (int k = 0; k < L; k++) begin
                term_d[k] = tap_term(hist_d[k], coef_q[k]);
            end
        end else begin
            hist_d = hist_q;
            term_d = term_q;
        end
        v1_d = accept_s;
    end

    // Stage 2: full-width sum, saturation, output hold between strobes.
    always_comb begin
        sum_s = '0;
        for (int k = 0; k < L; k++) begin
            sum_s = sum_s + SW'(term_q[k]);
        end
        if (!v1_q) begin
            out_d = out_q;
        end else if (sum_s > SAT_MAX) begin
            out_d = SAT_MAX[R-1:0];
        end else if (sum_s < SAT_MIN) begin
            out_d = SAT_MIN[R-1:0];
        end else begin
            out_d = sum_s[R-1:0];
        end
        vout_d = v1_q;
    end

    // Tap storage is intentionally not reset; written_q gates its use.
    always_ff @(posedge clk) begin
        coef_q <= coef_d;
    end

    // Control, history and pipeline state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_LOAD;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
            written_q <= '0;
            hist_q    <= '{default: '0};
            term_q    <= '{default: '0};
            v1_q      <= 1'b0;
            out_q     <= '0;
            vout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
            written_q <= written_d;
            hist_q    <= hist_d;
            term_q    <= term_d;
            v1_q      <= v1_d;
            out_q     <= out_d;
            vout_q    <= vout_d;
        end
    end

    assign bus.done_load        = done_q;
    assign bus.symbol_in_ready  = ready_q;
    assign bus.signal_out       = out_q;
    assign bus.signal_out_valid = vout_q;
endmodule
